// File: rtl/unmac_div_if.sv
// -----------------------------------------------------------------------------
// unmac_div_if -- operand / result bundle for the unmac_div divider.
//
// Carries both valid/ready handshakes and their payloads:
//   i_mac, i_add, i_divisor, i_valid, o_ready : operand side (into divider)
//   o_quotient, o_remainder, o_ovf, o_dbz,
//   o_valid, i_ready                          : result side (out of divider)
//   i_tc (only with UNMAC_TC_EN)              : two's-complement select
//
// Modports:
//   slave  : the divider itself
//   master : the block that supplies operands and consumes results
//
// Optional feature macro: UNMAC_TC_EN (adds i_tc).
// -----------------------------------------------------------------------------
interface unmac_div_if #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16,
    parameter int P_WIDTH = 32
);
    logic [P_WIDTH-1:0] i_mac;
    logic [P_WIDTH-1:0] i_add;
    logic [B_WIDTH-1:0] i_divisor;
    logic               i_valid;
    logic               o_ready;
`ifdef UNMAC_TC_EN
    logic               i_tc;
`endif
    logic               o_valid;
    logic               i_ready;
    logic [A_WIDTH-1:0] o_quotient;
    logic [B_WIDTH-1:0] o_remainder;
    logic               o_ovf;
    logic               o_dbz;

    modport slave (
`ifdef UNMAC_TC_EN
        input  i_tc,
`endif
        input  i_mac,
        input  i_add,
        input  i_divisor,
        input  i_valid,
        output o_ready,
        output o_valid,
        input  i_ready,
        output o_quotient,
        output o_remainder,
        output o_ovf,
        output o_dbz
    );

    modport master (
`ifdef UNMAC_TC_EN
        output i_tc,
`endif
        output i_mac,
        output i_add,
        output i_divisor,
        output i_valid,
        input  o_ready,
        input  o_valid,
        output i_ready,
        input  o_quotient,
        input  o_remainder,
        input  o_ovf,
        input  o_dbz
    );
endinterface

// File: rtl/unmac_div.sv
// -----------------------------------------------------------------------------
// unmac_div -- recovers the multiplicand from a 16x16+32 MAC result.
//
// Computes D = i_mac - i_add (mod 2^P_WIDTH) and divides D by i_divisor with
// an iterative restoring divider, one quotient bit per clock.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low; clears all state and outputs
//   bus    : unmac_div_if.slave -- operand handshake (i_valid/o_ready),
//            result handshake (o_valid/i_ready), quotient, remainder,
//            overflow and divide-by-zero flags
//
// Latency from the accepting edge (edge 0): result valid after edge
// P_WIDTH+1 normally, after edge 2 for a zero divisor.
//
// Optional feature macro: UNMAC_TC_EN -- adds bus.i_tc; when set, D and the
// divisor are treated as two's complement (truncating quotient, remainder
// takes the sign of D).
// -----------------------------------------------------------------------------
module unmac_div #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16,
    parameter int P_WIDTH = 32    // must equal A_WIDTH + B_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    unmac_div_if.slave bus
);
    localparam int CNT_W = $clog2(P_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DIV,
        DONE
    } state_t;

    state_t             state_q;
    logic [P_WIDTH-1:0] mac_q;
    logic [P_WIDTH-1:0] add_q;
    // Holds the raw divisor after capture, its magnitude once SUB has run.
    logic [B_WIDTH-1:0] div_q;
    // Dividend shift register; quotient bits shift in at the LSB as dividend
    // bits leave at the MSB, so after P_WIDTH steps it holds the quotient.
    logic [P_WIDTH-1:0] dq_q;
    logic [B_WIDTH-1:0] rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               dbz_q;
    logic               q_neg_q;
    logic               r_neg_q;
`ifdef UNMAC_TC_EN
    logic               tc_q;
`endif

    logic               o_valid_q;
    logic [A_WIDTH-1:0] o_quotient_q;
    logic [B_WIDTH-1:0] o_remainder_q;
    logic               o_ovf_q;
    logic               o_dbz_q;

    // Combinational datapath
    logic [P_WIDTH-1:0] diff_d;
    logic [P_WIDTH-1:0] dmag_d;
    logic [B_WIDTH-1:0] dvs_mag_d;
    logic               d_neg_d;
    logic               v_neg_d;
    logic [B_WIDTH:0]   shift_d;
    logic               qbit_d;
    logic [B_WIDTH-1:0] rem_d;
    logic [P_WIDTH-1:0] qfull_d;
    logic [P_WIDTH-1:0] qres_d;
    logic [B_WIDTH-1:0] rres_d;
    logic               ovf_d;

`ifdef UNMAC_TC_EN
    // Magnitude of the most negative A_WIDTH-bit value.
    localparam logic [P_WIDTH-1:0] SMIN_MAG = P_WIDTH'(1) << (A_WIDTH - 1);
`endif

    always_comb begin
        diff_d = mac_q - add_q;
`ifdef UNMAC_TC_EN
        d_neg_d = tc_q & diff_d[P_WIDTH-1];
        v_neg_d = tc_q & div_q[B_WIDTH-1];
`else
        d_neg_d = 1'b0;
        v_neg_d = 1'b0;
`endif
        dmag_d    = d_neg_d ? (P_WIDTH'(0) - diff_d) : diff_d;
        dvs_mag_d = v_neg_d ? (B_WIDTH'(0) - div_q) : div_q;

        // One restoring step: the B_WIDTH+1 bit trial remainder is compared
        // against the divisor; the result always fits back in B_WIDTH bits.
        shift_d = {rem_q, dq_q[P_WIDTH-1]};
        qbit_d  = (shift_d >= {1'b0, div_q});
        rem_d   = shift_d[B_WIDTH-1:0] - (qbit_d ? div_q : B_WIDTH'(0));
        qfull_d = {dq_q[P_WIDTH-2:0], qbit_d};

        // Sign fix-up applied on the final step so latency is unchanged.
        qres_d = q_neg_q ? (P_WIDTH'(0) - qfull_d) : qfull_d;
        rres_d = r_neg_q ? (B_WIDTH'(0) - rem_d) : rem_d;

`ifdef UNMAC_TC_EN
        if (tc_q) begin
            ovf_d = q_neg_q ? (qfull_d > SMIN_MAG) : (qfull_d >= SMIN_MAG);
        end else begin
            ovf_d = |qfull_d[P_WIDTH-1:A_WIDTH];
        end
`else
        ovf_d = |qfull_d[P_WIDTH-1:A_WIDTH];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            mac_q         <= '0;
            add_q         <= '0;
            div_q         <= '0;
            dq_q          <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            dbz_q         <= 1'b0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
`ifdef UNMAC_TC_EN
            tc_q          <= 1'b0;
`endif
            o_valid_q     <= 1'b0;
            o_quotient_q  <= '0;
            o_remainder_q <= '0;
            o_ovf_q       <= 1'b0;
            o_dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        mac_q   <= bus.i_mac;
                        add_q   <= bus.i_add;
                        div_q   <= bus.i_divisor;
`ifdef UNMAC_TC_EN
                        tc_q    <= bus.i_tc;
`endif
                        state_q <= SUB;
                    end
                end

                SUB: begin
                    rem_q   <= '0;
                    cnt_q   <= CNT_W'(P_WIDTH - 1);
                    q_neg_q <= d_neg_d ^ v_neg_d;
                    r_neg_q <= d_neg_d;
                    if (div_q == '0) begin
                        // Raw D is kept so its low bits can be reported.
                        dbz_q <= 1'b1;
                        dq_q  <= diff_d;
                    end else begin
                        dbz_q <= 1'b0;
                        dq_q  <= dmag_d;
                        div_q <= dvs_mag_d;
                    end
                    state_q <= DIV;
                end

                DIV: begin
                    if (dbz_q) begin
                        // Zero divisor: single pass through DIV publishes the
                        // status result, giving a two-edge latency.
                        o_quotient_q  <= '1;
                        o_remainder_q <= dq_q[B_WIDTH-1:0];
                        o_ovf_q       <= 1'b0;
                        o_dbz_q       <= 1'b1;
                        o_valid_q     <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        rem_q <= rem_d;
                        dq_q  <= qfull_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            o_quotient_q  <= qres_d[A_WIDTH-1:0];
                            o_remainder_q <= rres_d;
                            o_ovf_q       <= ovf_d;
                            o_dbz_q       <= 1'b0;
                            o_valid_q     <= 1'b1;
                            state_q       <= DONE;
                        end
                    end
                end

                DONE: begin
                    // No operand acceptance here, whatever i_valid does.
                    if (bus.i_ready) begin
                        o_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign bus.o_ready     = reset & (state_q == IDLE);
    assign bus.o_valid     = o_valid_q;
    assign bus.o_quotient  = o_quotient_q;
    assign bus.o_remainder = o_remainder_q;
    assign bus.o_ovf       = o_ovf_q;
    assign bus.o_dbz       = o_dbz_q;

endmodule
